// File: rtl/cc_stack_if.sv
// Handshake bundle for the condition-code unit: control/data into the unit,
// registered codes, branch decision and stack status back out.
interface cc_stack_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned LW = $clog2(DEPTH + 1);

    logic             LD_CC;
    logic [WIDTH-1:0] data;
    logic             push;
    logic             pop;
    logic             clear_err;
    logic [2:0]       br_mask;
    logic             N;
    logic             Z;
    logic             P;
    logic             br_taken;
    logic [LW-1:0]    level;
    logic             ovf;
    logic             unf;

    modport master (
        output LD_CC, data, push, pop, clear_err, br_mask,
        input  N, Z, P, br_taken, level, ovf, unf
    );

    modport slave (
        input  LD_CC, data, push, pop, clear_err, br_mask,
        output N, Z, P, br_taken, level, ovf, unf
    );
endinterface

// File: rtl/cc_stack.sv
// Condition-code register with N/Z/P classification, branch evaluation and a
// LIFO save/restore stack with sticky overflow/underflow flags.
module cc_stack #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input logic        clk,
    input logic        reset,
    cc_stack_if.slave  bus
);
    localparam int unsigned LW = $clog2(DEPTH + 1);
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [2:0]    cc_q, cc_d;
    logic [LW-1:0] level_q, level_d;
    logic          ovf_q, ovf_d;
    logic          unf_q, unf_d;
    logic [2:0]    stack_q [DEPTH];

    logic          full, empty;
    logic          push_only, pop_only;
    logic          do_push, do_pop;
    logic [2:0]    data_cc;
    logic [IW-1:0] push_idx, pop_idx;

    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    // A simultaneous push and pop cancel out entirely.
    assign push_only = bus.push & ~bus.pop;
    assign pop_only  = bus.pop & ~bus.push;
    assign do_push   = push_only & ~full;
    assign do_pop    = pop_only & ~empty;
    assign push_idx  = IW'(level_q);
    assign pop_idx   = IW'(level_q - LW'(1));

    always_comb begin
        data_cc[2] = bus.data[WIDTH-1];
        data_cc[1] = (bus.data == '0);
        data_cc[0] = ~data_cc[2] & ~data_cc[1];
    end

    always_comb begin
        cc_d    = cc_q;
        level_d = level_q;
        ovf_d   = bus.clear_err ? 1'b0 : ovf_q;
        unf_d   = bus.clear_err ? 1'b0 : unf_q;
        if (do_pop) begin
            cc_d    = stack_q[pop_idx];
            level_d = level_q - LW'(1);
        end else if (bus.LD_CC) begin
            cc_d = data_cc;
        end
        if (do_push) level_d = level_q + LW'(1);
        if (push_only && full) ovf_d = 1'b1;
        if (pop_only && empty) unf_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cc_q    <= 3'b000;
            level_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            cc_q    <= cc_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        if (do_push) stack_q[push_idx] <= cc_q;
    end

    assign bus.N        = cc_q[2];
    assign bus.Z        = cc_q[1];
    assign bus.P        = cc_q[0];
    assign bus.br_taken = |(bus.br_mask & cc_q);
    assign bus.level    = level_q;
    assign bus.ovf      = ovf_q;
    assign bus.unf      = unf_q;
endmodule

// File: tb/tb_cc_stack.sv
// Directed self-checking bench for cc_stack at WIDTH=16 and WIDTH=8.
module tb_cc_stack;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total  = 0;

    cc_stack_if #(.WIDTH(16), .DEPTH(4)) b ();
    cc_stack_if #(.WIDTH(8),  .DEPTH(4)) b8 ();

    cc_stack #(.WIDTH(16), .DEPTH(4)) dut (.clk(clk), .reset(reset), .bus(b));
    cc_stack #(.WIDTH(8),  .DEPTH(4)) dut8 (.clk(clk), .reset(reset), .bus(b8));

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        b.LD_CC = 0; b.data = '0; b.push = 0; b.pop = 0; b.clear_err = 0; b.br_mask = 3'b000;
        b8.LD_CC = 0; b8.data = '0; b8.push = 0; b8.pop = 0; b8.clear_err = 0;
        b8.br_mask = 3'b000;
    endtask

    task automatic load(input logic [15:0] d);
        b.LD_CC = 1; b.data = d;
        step();
        b.LD_CC = 0;
    endtask

    task automatic test_reset();
        b.br_mask = 3'b111;
        step();
        total++; if ({b.N, b.Z, b.P} !== 3'b000) $display("FAIL reset_cc: got %b want 000", {b.N, b.Z, b.P}); else passed++;
        total++; if (b.br_taken !== 1'b0) $display("FAIL reset_br: got %b want 0", b.br_taken); else passed++;
        total++; if (b.level !== 3'd0) $display("FAIL reset_level: got %0d want 0", b.level); else passed++;
        total++; if ({b.ovf, b.unf} !== 2'b00) $display("FAIL reset_flags: got %b want 00", {b.ovf, b.unf}); else passed++;
    endtask

    task automatic test_classify();
        logic [15:0] d   [4] = '{16'hFFFB, 16'h0000, 16'h0005, 16'h8000};
        logic [2:0]  exp [4] = '{3'b100, 3'b010, 3'b001, 3'b100};
        for (int i = 0; i < 4; i++) begin
            load(d[i]);
            total++; if ({b.N, b.Z, b.P} !== exp[i]) $display("FAIL classify_%0d: got %b want %b", i, {b.N, b.Z, b.P}, exp[i]); else passed++;
            b.br_mask = exp[i]; #1;
            total++; if (b.br_taken !== 1'b1) $display("FAIL br_taken_%0d: got %b want 1", i, b.br_taken); else passed++;
            b.br_mask = ~exp[i]; #1;
            total++; if (b.br_taken !== 1'b0) $display("FAIL br_not_%0d: got %b want 0", i, b.br_taken); else passed++;
        end
        b.br_mask = 3'b000;
    endtask

    task automatic test_width8();
        b8.LD_CC = 1; b8.data = 8'h7F;
        step();
        total++; if ({b8.N, b8.Z, b8.P} !== 3'b001) $display("FAIL w8_7f: got %b want 001", {b8.N, b8.Z, b8.P}); else passed++;
        b8.data = 8'h80;
        step();
        b8.LD_CC = 0;
        total++; if ({b8.N, b8.Z, b8.P} !== 3'b100) $display("FAIL w8_80: got %b want 100", {b8.N, b8.Z, b8.P}); else passed++;
    endtask

    task automatic test_save_restore();
        load(16'hFFFB);
        b.push = 1; b.LD_CC = 1; b.data = 16'h0000;
        step();
        b.push = 0; b.LD_CC = 0;
        total++; if ({b.N, b.Z, b.P} !== 3'b010) $display("FAIL sr_push_cc: got %b want 010", {b.N, b.Z, b.P}); else passed++;
        total++; if (b.level !== 3'd1) $display("FAIL sr_push_level: got %0d want 1", b.level); else passed++;
        // LD_CC alongside a valid pop must lose
        b.pop = 1; b.LD_CC = 1; b.data = 16'h0005;
        step();
        b.pop = 0; b.LD_CC = 0;
        total++; if ({b.N, b.Z, b.P} !== 3'b100) $display("FAIL sr_pop_cc: got %b want 100", {b.N, b.Z, b.P}); else passed++;
        total++; if (b.level !== 3'd0) $display("FAIL sr_pop_level: got %0d want 0", b.level); else passed++;
    endtask

    task automatic test_stack_full();
        logic [15:0] d   [5] = '{16'h0005, 16'h0000, 16'hFFFF, 16'h0007, 16'h0000};
        logic [2:0]  pex [4] = '{3'b001, 3'b100, 3'b010, 3'b001};
        for (int i = 0; i < 5; i++) begin
            load(d[i]);
            b.push = 1;
            step();
            b.push = 0;
        end
        total++; if (b.level !== 3'd4) $display("FAIL full_level: got %0d want 4", b.level); else passed++;
        total++; if (b.ovf !== 1'b1) $display("FAIL full_ovf: got %b want 1", b.ovf); else passed++;
        total++; if (b.unf !== 1'b0) $display("FAIL full_unf: got %b want 0", b.unf); else passed++;
        load(16'h0000);
        for (int i = 0; i < 4; i++) begin
            b.pop = 1;
            step();
            b.pop = 0;
            total++; if ({b.N, b.Z, b.P} !== pex[i]) $display("FAIL pop_cc_%0d: got %b want %b", i, {b.N, b.Z, b.P}, pex[i]); else passed++;
            total++; if (b.level !== 3'(3 - i)) $display("FAIL pop_level_%0d: got %0d want %0d", i, b.level, 3 - i); else passed++;
        end
        b.clear_err = 1;
        step();
        b.clear_err = 0;
        total++; if (b.ovf !== 1'b0) $display("FAIL ovf_clear: got %b want 0", b.ovf); else passed++;
    endtask

    task automatic test_underflow();
        load(16'h0000);
        b.pop = 1; b.LD_CC = 1; b.data = 16'h0007;
        step();
        b.pop = 0; b.LD_CC = 0;
        total++; if (b.unf !== 1'b1) $display("FAIL unf_set: got %b want 1", b.unf); else passed++;
        total++; if ({b.N, b.Z, b.P} !== 3'b001) $display("FAIL unf_cc: got %b want 001", {b.N, b.Z, b.P}); else passed++;
        total++; if (b.level !== 3'd0) $display("FAIL unf_level: got %0d want 0", b.level); else passed++;
        b.clear_err = 1;
        step();
        total++; if (b.unf !== 1'b0) $display("FAIL unf_clear: got %b want 0", b.unf); else passed++;
        b.pop = 1;
        step();
        b.pop = 0; b.clear_err = 0;
        total++; if (b.unf !== 1'b1) $display("FAIL unf_wins: got %b want 1", b.unf); else passed++;
        b.clear_err = 1;
        step();
        b.clear_err = 0;
    endtask

    task automatic test_collision();
        load(16'hFFFF);
        b.push = 1; step(); b.push = 0;
        load(16'h0000);
        b.push = 1; step(); b.push = 0;
        load(16'h0005);
        b.push = 1; b.pop = 1; b.LD_CC = 1; b.data = 16'hFFFF;
        step();
        b.push = 0; b.pop = 0; b.LD_CC = 0;
        total++; if (b.level !== 3'd2) $display("FAIL coll_level: got %0d want 2", b.level); else passed++;
        total++; if ({b.N, b.Z, b.P} !== 3'b100) $display("FAIL coll_cc: got %b want 100", {b.N, b.Z, b.P}); else passed++;
        total++; if ({b.ovf, b.unf} !== 2'b00) $display("FAIL coll_flags: got %b want 00", {b.ovf, b.unf}); else passed++;
        b.pop = 1; step();
        total++; if ({b.N, b.Z, b.P} !== 3'b010) $display("FAIL coll_pop1: got %b want 010", {b.N, b.Z, b.P}); else passed++;
        step(); b.pop = 0;
        total++; if ({b.N, b.Z, b.P} !== 3'b100) $display("FAIL coll_pop0: got %b want 100", {b.N, b.Z, b.P}); else passed++;
    endtask

    task automatic test_async_reset();
        load(16'h0005);
        b.push = 1;
        for (int i = 0; i < 5; i++) step();
        b.push = 0;
        b.pop = 1; step(); b.pop = 0;
        load(16'hFFFF);
        total++; if ({b.level, b.ovf} !== {3'd3, 1'b1}) $display("FAIL pre_reset: got %0d/%b want 3/1", b.level, b.ovf); else passed++;
        b.br_mask = 3'b111;
        #2 reset = 1;
        #1;
        total++; if ({b.N, b.Z, b.P} !== 3'b000) $display("FAIL async_cc: got %b want 000", {b.N, b.Z, b.P}); else passed++;
        total++; if (b.level !== 3'd0) $display("FAIL async_level: got %0d want 0", b.level); else passed++;
        total++; if ({b.ovf, b.unf} !== 2'b00) $display("FAIL async_flags: got %b want 00", {b.ovf, b.unf}); else passed++;
        total++; if (b.br_taken !== 1'b0) $display("FAIL async_br: got %b want 0", b.br_taken); else passed++;
        step();
        reset = 0;
        step();
        total++; if (b.level !== 3'd0) $display("FAIL post_reset_level: got %0d want 0", b.level); else passed++;
    endtask

    initial begin
        idle_inputs();
        step();
        step();
        reset = 0;
        test_reset();
        test_classify();
        test_width8();
        test_save_restore();
        test_stack_full();
        test_underflow();
        test_collision();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
